// File: rtl/uart_pkg.sv
// Shared UART constants: default divisor/fraction, oversample ratio and divisor limit.
package uart_pkg;

    localparam int unsigned DEFAULT_DIV  = 651;
    localparam int unsigned DEFAULT_FRAC = 0;
    localparam int unsigned OS           = 16;
    localparam int unsigned FRAC_BITS    = 4;
    localparam int unsigned MIN_DIV      = 2;

    function automatic logic div_in_range(input int unsigned div);
        return div >= MIN_DIV;
    endfunction

endpackage

// File: rtl/baud_os_counter.sv
// Oversample phase counter: counts oversample wraps and decodes the mid-bit and bit ticks.
module baud_os_counter #(
    parameter int unsigned OS = uart_pkg::OS
) (
    input  logic clk,
    input  logic reset,
    input  logic wrap,
    input  logic sync,
    output logic tick_mid,
    output logic tick
);
    import uart_pkg::*;

    localparam int unsigned W = $clog2(OS);
    localparam logic [W-1:0] LAST     = W'(OS - 1);
    localparam logic [W-1:0] MID_PREV = W'(OS / 2 - 1);

    logic [W-1:0] os_cnt;

    always_ff @(posedge clk) begin
        if (reset || sync) begin
            os_cnt   <= '0;
            tick_mid <= 1'b0;
            tick     <= 1'b0;
        end else begin
            tick_mid <= wrap && (os_cnt == MID_PREV);
            tick     <= wrap && (os_cnt == LAST);
            if (wrap) begin
                os_cnt <= (os_cnt == LAST) ? '0 : os_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/baud_rate_gen.sv
// Programmable UART baud tick generator with shadowed divisor writes and phase resync.
// Define BAUD_FRAC_EN to enable the fractional divisor accumulator.
module baud_rate_gen #(
    parameter int unsigned N            = 16,
    parameter int unsigned FRAC_BITS    = uart_pkg::FRAC_BITS,
    parameter int unsigned OS           = uart_pkg::OS,
    parameter int unsigned DEFAULT_DIV  = uart_pkg::DEFAULT_DIV,
    parameter int unsigned DEFAULT_FRAC = uart_pkg::DEFAULT_FRAC
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 div_wr_i,
    input  logic [N-1:0]         div_i,
    input  logic [FRAC_BITS-1:0] frac_i,
    input  logic                 sync_i,
    output logic                 div_err_o,
    output logic                 tick_os_o,
    output logic                 tick_mid_o,
    output logic                 tick_o,
    output logic [N-1:0]         count_o
);
    import uart_pkg::*;

    logic [N-1:0] div_q;
    logic [N-1:0] shadow_div;
    logic [N-1:0] next_div;
    logic [N-1:0] count;
    logic [N:0]   d_eff;
    logic         pending;
    logic         next_pending;
    logic         extra;
    logic         wr_ok;
    logic         wr_bad;
    logic         at_end;
    logic         wrap;
    logic         apply_now;
    logic         tick_os;
    logic         div_err;

    // A write landing on the wrap cycle (or with enable low / sync high) is applied
    // straight away, so the shadow is bypassed combinationally.
    always_comb begin
        wr_ok        = div_wr_i && div_in_range(32'(div_i));
        wr_bad       = div_wr_i && !wr_ok;
        next_div     = wr_ok ? div_i : shadow_div;
        next_pending = pending || wr_ok;
        d_eff        = {1'b0, div_q} + {{N{1'b0}}, extra};
        at_end       = ({1'b0, count} >= (d_eff - 1'b1));
        wrap         = enable_i && !sync_i && at_end;
        apply_now    = next_pending && (!enable_i || sync_i || wrap);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q      <= N'(DEFAULT_DIV);
            shadow_div <= N'(DEFAULT_DIV);
            pending    <= 1'b0;
            count      <= '0;
            tick_os    <= 1'b0;
            div_err    <= 1'b0;
        end else begin
            div_err <= wr_bad;
            tick_os <= wrap;
            if (wr_ok) begin
                shadow_div <= div_i;
            end
            if (apply_now) begin
                div_q   <= next_div;
                pending <= 1'b0;
            end else if (wr_ok) begin
                pending <= 1'b1;
            end
            if (sync_i) begin
                count <= '0;
            end else if (enable_i) begin
                count <= at_end ? '0 : count + 1'b1;
            end else if (apply_now && (count >= next_div)) begin
                count <= '0;
            end
        end
    end

`ifdef BAUD_FRAC_EN
    logic [FRAC_BITS-1:0] frac_q;
    logic [FRAC_BITS-1:0] shadow_frac;
    logic [FRAC_BITS-1:0] next_frac;
    logic [FRAC_BITS-1:0] frac_acc;
    logic [FRAC_BITS:0]   frac_sum;

    always_comb begin
        frac_sum  = {1'b0, frac_acc} + {1'b0, frac_q};
        next_frac = wr_ok ? frac_i : shadow_frac;
    end

    // The carry out of this wrap lengthens the following period by one cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            frac_q      <= FRAC_BITS'(DEFAULT_FRAC);
            shadow_frac <= FRAC_BITS'(DEFAULT_FRAC);
            frac_acc    <= '0;
            extra       <= 1'b0;
        end else begin
            if (wr_ok) begin
                shadow_frac <= frac_i;
            end
            if (apply_now) begin
                frac_q <= next_frac;
            end
            if (sync_i) begin
                frac_acc <= '0;
                extra    <= 1'b0;
            end else if (wrap) begin
                frac_acc <= frac_sum[FRAC_BITS-1:0];
                extra    <= frac_sum[FRAC_BITS];
            end
        end
    end
`else
    logic unused_frac;

    assign extra       = 1'b0;
    assign unused_frac = ^{frac_i, FRAC_BITS'(DEFAULT_FRAC)};
`endif

    baud_os_counter #(
        .OS(OS)
    ) u_os_counter (
        .clk      (clk_i),
        .reset    (reset_i),
        .wrap     (wrap),
        .sync     (sync_i),
        .tick_mid (tick_mid_o),
        .tick     (tick_o)
    );

    assign tick_os_o = tick_os;
    assign div_err_o = div_err;
    assign count_o   = count;

endmodule

// File: tb/tb_baud_rate_gen.sv
// Self-checking bench for baud_rate_gen: directed scenarios plus random traffic against a cycle-level reference model.
module tb_baud_rate_gen;
    import uart_pkg::*;

    localparam int unsigned NW  = 16;
    localparam int unsigned FB  = 4;
    localparam int unsigned OSR = 16;

    logic          clk = 1'b0;
    logic          rst, en, wr, sy;
    logic [NW-1:0] dv;
    logic [FB-1:0] fr;
    logic          err, tos, tmid, tbit;
    logic [NW-1:0] cnt;

    baud_rate_gen #(
        .N(NW), .FRAC_BITS(FB), .OS(OSR), .DEFAULT_DIV(651), .DEFAULT_FRAC(0)
    ) dut (
        .clk_i(clk), .reset_i(rst), .enable_i(en), .div_wr_i(wr), .div_i(dv),
        .frac_i(fr), .sync_i(sy), .div_err_o(err), .tick_os_o(tos),
        .tick_mid_o(tmid), .tick_o(tbit), .count_o(cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_tick = -1;
    int last_period = 0;

    // Reference model: elapsed cycles in the period, period length, wraps since phase start.
    int m_div, m_shadow_div, m_count, m_extra, m_ticks;
    bit m_pend;
`ifdef BAUD_FRAC_EN
    int m_frac, m_shadow_frac, m_acc;
`endif
    bit e_err, e_os, e_mid, e_bit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic apply_shadow();
        if (m_pend) begin
            m_div = m_shadow_div;
`ifdef BAUD_FRAC_EN
            m_frac = m_shadow_frac;
`endif
            m_pend = 0;
        end
    endtask

    task automatic model_step();
        e_err = 0; e_os = 0; e_mid = 0; e_bit = 0;
        if (rst) begin
            m_div = 651; m_shadow_div = 651; m_pend = 0;
            m_count = 0; m_extra = 0; m_ticks = 0;
`ifdef BAUD_FRAC_EN
            m_frac = 0; m_shadow_frac = 0; m_acc = 0;
`endif
            return;
        end
        if (wr) begin
            if (dv < 2) e_err = 1;
            else begin
                m_shadow_div = int'(dv);
`ifdef BAUD_FRAC_EN
                m_shadow_frac = int'(fr);
`endif
                m_pend = 1;
            end
        end
        if (sy) begin
            apply_shadow();
            m_count = 0; m_ticks = 0; m_extra = 0;
`ifdef BAUD_FRAC_EN
            m_acc = 0;
`endif
        end else if (en) begin
            if (m_count == m_div + m_extra - 1) begin
                m_count = 0;
                m_ticks++;
                e_os  = 1;
                e_mid = (m_ticks % OSR) == OSR / 2;
                e_bit = (m_ticks % OSR) == 0;
`ifdef BAUD_FRAC_EN
                m_acc   = m_acc + m_frac;
                m_extra = (m_acc >= (1 << FB)) ? 1 : 0;
                m_acc   = m_acc % (1 << FB);
`endif
                apply_shadow();
            end else begin
                m_count++;
            end
        end else if (m_pend) begin
            apply_shadow();
            if (m_count >= m_div) m_count = 0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("count", 32'(cnt), m_count);
        check("tick_os", 32'(tos), 32'(e_os));
        check("tick_mid", 32'(tmid), 32'(e_mid));
        check("tick", 32'(tbit), 32'(e_bit));
        check("div_err", 32'(err), 32'(e_err));
        if (tos === 1'b1) begin
            if (last_tick >= 0) last_period = cyc - last_tick;
            last_tick = cyc;
        end
    endtask

    // which: 0 = tick_os, 1 = tick_mid, 2 = tick
    task automatic wait_for(input int which, input int max_cycles);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < max_cycles && !hit; i++) begin
            cycle();
            hit = (which == 0) ? (tos === 1'b1) : (which == 1) ? (tmid === 1'b1) : (tbit === 1'b1);
        end
        check($sformatf("wait_tick_%0d", which), 32'(hit), 1);
    endtask

    task automatic wait_count(input int value, input int max_cycles);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < max_cycles && !hit; i++) begin
            cycle();
            hit = (cnt === NW'(value));
        end
        check("wait_count", 32'(hit), 1);
    endtask

    initial begin
        int start;
        int n;

        // Reset overrides write/sync/enable activity.
        rst = 1; en = 1; wr = 1; sy = 1; dv = '0; fr = '0;
        repeat (3) cycle();
        check("reset_count", 32'(cnt), 0);
        rst = 0; wr = 0; sy = 0; en = 1;
        start = cyc;

        wait_for(0, 2000);
        check("first_tick_cycle", cyc - start, 651);
        repeat (3) cycle();
        check("count_after_tick", 32'(cnt), 3);

        wait_for(1, 10000);
        check("mid_cycle", cyc - start, 5208);
        check("mid_with_os", 32'(tos), 1);
        wait_for(2, 10000);
        check("bit_cycle", cyc - start, 10416);
        check("bit_with_os", 32'(tos), 1);

        // Deferred write does not disturb the running period.
        wait_count(300, 1000);
        wr = 1; dv = 100; cycle(); wr = 0;
        wait_for(0, 1000);
        check("period_unchanged", last_period, 651);
        wait_for(0, 1000);
        check("new_period", last_period, 100);

        // Rejected divisor.
        wait_count(50, 200);
        wr = 1; dv = 1; cycle(); wr = 0;
        check("div_err_pulse", 32'(err), 1);
        cycle();
        check("div_err_clear", 32'(err), 0);
        wait_for(0, 200);
        wait_for(0, 200);
        check("period_after_bad_write", last_period, 100);

        // Last of several writes wins.
        wait_count(10, 200);
        wr = 1; dv = 20; cycle();
        dv = 30; cycle(); wr = 0;
        wait_for(0, 200);
        wait_for(0, 200);
        check("last_write_wins", last_period, 30);

        // Fractional divisor over 16 periods.
        sy = 1; wr = 1; dv = 651; fr = 11; cycle(); sy = 0; wr = 0;
        check("sync_write_count", 32'(cnt), 0);
        wait_for(0, 1000);
        start = cyc;
        repeat (16) wait_for(0, 1000);
`ifdef BAUD_FRAC_EN
        check("frac_16_periods", cyc - start, 10427);
`else
        check("frac_16_periods", cyc - start, 10416);
`endif

        // Resync mid-frame.
        sy = 1; wr = 1; dv = 651; fr = 0; cycle(); sy = 0; wr = 0;
        repeat (5) wait_for(0, 1000);
        wait_count(400, 1000);
        sy = 1; cycle(); sy = 0;
        start = cyc;
        check("sync_count", 32'(cnt), 0);
        wait_for(0, 1000);
        check("sync_first_tick", cyc - start, 651);
        n = 1;
        while (tmid !== 1'b1 && n < 20) begin
            wait_for(0, 1000);
            n++;
        end
        check("mid_tick_index", n, 8);

        // Disable holds; immediate shrink below count clears it.
        wait_count(200, 1000);
        en = 0;
        repeat (5) cycle();
        check("hold_count", 32'(cnt), 200);
        wr = 1; dv = 50; cycle(); wr = 0;
        check("shrink_zero", 32'(cnt), 0);
        en = 1;
        start = cyc;
        wait_for(0, 200);
        check("period_after_shrink", cyc - start, 50);

        // Random traffic with short divisors.
        sy = 1; wr = 1; dv = 6; cycle(); sy = 0; wr = 0;
        repeat (4000) begin
            en = ($urandom_range(0, 9) != 0);
            sy = ($urandom_range(0, 99) == 0);
            wr = ($urandom_range(0, 29) == 0);
            dv = NW'($urandom_range(0, 24));
            fr = FB'($urandom);
            cycle();
        end

        rst = 1; en = 1; wr = 0; sy = 0;
        cycle();
        check("final_reset_count", 32'(cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
